// File: rtl/shift8l_serial_ctrl.sv
// Sequencer for an external 8-bit left shift register: one MSB-first, full-duplex byte per start.
// Optional: define SHIFT8L_SERIAL_LOOPBACK_EN to sample sdo instead of sdi (internal loopback).
module shift8l_serial_ctrl #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] tx_data,
   output logic       busy,
   output logic       done,
   output logic [7:0] rx_data,
   output logic       sclk,
   output logic       sdo,
   input  logic       sdi,
   output logic       sr_load,
   output logic       sr_shift,
   output logic [7:0] sr_in,
   output logic       sr_lsb,
   input  logic [7:0] sr_q
);

   typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, SHIFT, DONE} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t     state;
   state_t     state_next;
   logic [7:0] div_cnt;
   logic [2:0] bit_cnt;
   logic       sample;
   logic       sample_src;
   logic       sdo_en;
   logic       half_end;

   assign half_end = (div_cnt == DIV_LAST);
   assign sr_in    = tx_data;
   // sr_q moves on the shift edge, so the MSB is gated live rather than registered
   assign sdo      = sdo_en & sr_q[7];

`ifdef SHIFT8L_SERIAL_LOOPBACK_EN
   logic unused_sdi;
   assign unused_sdi = sdi;
   assign sample_src = sdo;
`else
   assign sample_src = sdi;
`endif

   always_comb begin
      // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = LOAD;
         LOAD:    state_next = LOW;
         LOW:     if (half_end) state_next = HIGH;
         HIGH:    if (half_end) state_next = SHIFT;
         SHIFT:   state_next = (bit_cnt == 3'd7) ? DONE : LOW;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         sample   <= 1'b0;
         rx_data  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sclk     <= 1'b0;
         sdo_en   <= 1'b0;
         sr_load  <= 1'b0;
         sr_shift <= 1'b0;
         sr_lsb   <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout; outputs are decoded from state_next so they
         // are registered yet line up with the state they belong to.
         state    <= state_next;
         busy     <= (state_next != IDLE);
         done     <= (state_next == DONE);
         sclk     <= (state_next == HIGH);
         sdo_en   <= (state_next inside {LOW, HIGH, SHIFT});
         sr_load  <= (state_next == LOAD);
         sr_shift <= (state_next == SHIFT);
         sr_lsb   <= (state_next == SHIFT) ? sample : 1'b0;

         if (state == LOW || state == HIGH)
            div_cnt <= half_end ? 8'd0 : div_cnt + 8'd1;

         if (state == LOW && half_end)
            sample <= sample_src;

         if (state == SHIFT) begin
            if (bit_cnt == 3'd7) begin
               // sr_q is still pre-shift here, so append the bit being inserted
               rx_data <= {sr_q[6:0], sample};
               bit_cnt <= 3'd0;
            end else begin
               bit_cnt <= bit_cnt + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_shift8l_serial_ctrl.sv
// Bench for shift8l_serial_ctrl: behavioural shift register + serial slave, scoreboard on done.
// Runs CLK_DIV=2 (main) and CLK_DIV=1 instances; honours SHIFT8L_SERIAL_LOOPBACK_EN.
module tb_shift8l_serial_ctrl;

`ifdef SHIFT8L_SERIAL_LOOPBACK_EN
   localparam bit LB = 1'b1;
`else
   localparam bit LB = 1'b0;
`endif
   localparam int LAT2 = 2 + 8 * (2 * 2 + 1);
   localparam int LAT1 = 2 + 8 * (2 * 1 + 1);

   typedef struct {
      logic [7:0] tx;
      logic [7:0] sl;
      logic [7:0] exp_rx;
   } vec_t;

   typedef struct {
      logic [7:0] rx;
      int         cyc;
   } sb_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;

   logic       start, busy, done, sclk, sdo, sdi, sr_load, sr_shift, sr_lsb;
   logic [7:0] tx_data, rx_data, sr_in;
   logic [7:0] sr_q = 8'hFF;
   logic [7:0] slave_byte;
   logic [3:0] sl_cnt = 4'd8;
   logic       sclk_d = 1'b0;
   logic [2:0] sl_idx;

   logic       start1, busy1, done1, sclk1, sdo1, sdi1, sr_load1, sr_shift1, sr_lsb1;
   logic [7:0] tx1, rx1, sr_in1;
   logic [7:0] sr_q1 = 8'hFF;
   logic [7:0] slave1;
   logic [3:0] sl_cnt1 = 4'd8;
   logic       sclk_d1 = 1'b0;
   logic [2:0] sl_idx1;

   int   checks = 0;
   int   errors = 0;
   int   ld_cnt = 0;
   int   sh_cnt = 0;
   sb_t  sb[$];
   logic sdo_q[$];
   vec_t vec[5];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   shift8l_serial_ctrl #(.CLK_DIV(2)) u_dut (
      .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
      .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk), .sdo(sdo), .sdi(sdi),
      .sr_load(sr_load), .sr_shift(sr_shift), .sr_in(sr_in), .sr_lsb(sr_lsb), .sr_q(sr_q)
   );

   shift8l_serial_ctrl #(.CLK_DIV(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start1), .tx_data(tx1),
      .busy(busy1), .done(done1), .rx_data(rx1), .sclk(sclk1), .sdo(sdo1), .sdi(sdi1),
      .sr_load(sr_load1), .sr_shift(sr_shift1), .sr_in(sr_in1), .sr_lsb(sr_lsb1), .sr_q(sr_q1)
   );

   // External shift registers (not reset: contents are undefined after an abort)
   always @(posedge clk) begin
      if (sr_load)       sr_q <= sr_in;
      else if (sr_shift) sr_q <= {sr_q[6:0], sr_lsb};
      if (sr_load1)       sr_q1 <= sr_in1;
      else if (sr_shift1) sr_q1 <= {sr_q1[6:0], sr_lsb1};
   end

   // Serial slaves: present MSB first, advance one cycle after each sclk rise
   always @(posedge clk) begin
      sclk_d  <= sclk;
      sclk_d1 <= sclk1;
      if (sr_load) sl_cnt <= 4'd0;
      else if (sclk && !sclk_d && !sl_cnt[3]) sl_cnt <= sl_cnt + 4'd1;
      if (sr_load1) sl_cnt1 <= 4'd0;
      else if (sclk1 && !sclk_d1 && !sl_cnt1[3]) sl_cnt1 <= sl_cnt1 + 4'd1;
   end
   assign sl_idx  = 3'd7 - sl_cnt[2:0];
   assign sl_idx1 = 3'd7 - sl_cnt1[2:0];
   assign sdi  = !sl_cnt[3] & slave_byte[sl_idx];
   assign sdi1 = !sl_cnt1[3] & slave1[sl_idx1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [7:0] tx, input logic [7:0] exp_rx);
      sb.push_back('{exp_rx, cyc + LAT2});
      for (int b = 7; b >= 0; b--) sdo_q.push_back(tx[b]);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", done, 1);
   endtask

   task automatic do_xfer(input logic [7:0] tx, input logic [7:0] sl, input logic [7:0] exp_rx);
      int ld0, sh0;
      tx_data    = tx;
      slave_byte = sl;
      ld0 = ld_cnt;
      sh0 = sh_cnt;
      push(tx, exp_rx);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      @(negedge clk);
      check("loads_per_xfer", ld_cnt - ld0, 1);
      check("shifts_per_xfer", sh_cnt - sh0, 8);
   endtask

   initial begin
      int   n, lds, shs, highs;
      logic prev_sclk;
      sb_t  e;

      vec[0] = '{8'hA5, 8'h3C, LB ? 8'hA5 : 8'h3C};
      vec[1] = '{8'h00, 8'hFF, LB ? 8'h00 : 8'hFF};
      vec[2] = '{8'hFF, 8'h00, LB ? 8'hFF : 8'h00};
      vec[3] = '{8'h81, 8'h7E, LB ? 8'h81 : 8'h7E};
      vec[4] = '{8'h96, 8'h00, LB ? 8'h96 : 8'h00};

      reset = 1'b1; start = 1'b0; tx_data = 8'h00; slave_byte = 8'h00;
      start1 = 1'b0; tx1 = 8'h00; slave1 = 8'h00;

      fork
         begin : monitor
            prev_sclk = 1'b0;
            forever begin
               @(negedge clk);
               if (reset) begin
                  prev_sclk = 1'b0;
               end else begin
                  if (sr_load)  ld_cnt++;
                  if (sr_shift) sh_cnt++;
                  if (sr_load && sr_shift) check("load_shift_exclusive", 1, 0);
                  if (sclk && !prev_sclk) begin
                     if (sdo_q.size() == 0) check("sdo_unexpected_rise", 1, 0);
                     else check("sdo_on_rise", sdo, sdo_q.pop_front());
                  end
                  prev_sclk = sclk;
                  if (done) begin
                     if (sb.size() == 0) begin
                        check("spurious_done", 1, 0);
                     end else begin
                        e = sb.pop_front();
                        check("rx_data", rx_data, e.rx);
                        check("done_cycle", cyc, e.cyc);
                     end
                  end
               end
            end
         end
      join_none

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ctrl", {busy, done, sclk, sdo, sr_load, sr_shift, sr_lsb}, 0);
      check("rst_rx_data", rx_data, 8'h00);
      reset = 1'b0;

      // Idle for 20 cycles with start low
      n = ld_cnt + sh_cnt;
      repeat (20) @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_sclk", sclk, 0);
      check("idle_sdo", sdo, 0);
      check("idle_rx_data", rx_data, 8'h00);
      check("idle_no_pulses", ld_cnt + sh_cnt - n, 0);
      check("idle_sr_in", sr_in, tx_data);

      // Table-driven transfers, back-to-back one cycle after DONE
      for (int i = 0; i < 5; i++) do_xfer(vec[i].tx, vec[i].sl, vec[i].exp_rx);

      // Starts during HIGH of bit 3 and during DONE must be ignored
      tx_data = 8'h3C; slave_byte = 8'hA5;
      push(8'h3C, LB ? 8'h3C : 8'hA5);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (18) @(negedge clk);
      check("bit3_high_phase", sclk, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("idle_after_done", busy, 0);
      repeat (3) @(negedge clk);
      check("start_not_queued", busy, 0);
      check("queue_drained", sb.size(), 0);
      do_xfer(8'hC3, 8'h18, LB ? 8'hC3 : 8'h18);

      // Asynchronous reset during HIGH of bit 5 aborts without done
      tx_data = 8'h5A; slave_byte = 8'hFF;
      push(8'h5A, LB ? 8'h5A : 8'hFF);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (28) @(negedge clk);
      check("bit5_high_phase", sclk, 1);
      #2 reset = 1'b1;
      #1;
      check("abort_ctrl", {busy, done, sclk, sdo, sr_load, sr_shift, sr_lsb}, 0);
      check("abort_rx_data", rx_data, 8'h00);
      sb.delete();
      sdo_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (50) @(negedge clk);
      check("abort_no_late_done", busy, 0);
      do_xfer(8'hFF, 8'h00, LB ? 8'hFF : 8'h00);

      // CLK_DIV=1 instance
      tx1 = 8'hC3; slave1 = 8'h5A;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 1; lds = 0; shs = 0; highs = 0;
      while (!done1 && n < 100) begin
         lds   += int'(sr_load1);
         shs   += int'(sr_shift1);
         highs += int'(sclk1);
         @(negedge clk);
         n++;
      end
      check("div1_done_cycle", n, LAT1);
      check("div1_loads", lds, 1);
      check("div1_shifts", shs, 8);
      check("div1_sclk_high_cycles", highs, 8);
      check("div1_rx_data", rx1, LB ? 8'hC3 : 8'h5A);
      @(negedge clk);
      check("div1_idle", busy1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
